vga_rx_monitor: RTL
===================

Name: vga_rx_monitor

Overview:
- Receiving end of the VGA timing/pixel interface driven by the team's VGA timing generator and pixel logic.
- Recovers pixel coordinates from blank/hsync/vsync and measures line and frame geometry against parameters.
- Produces a per-frame pixel checksum so the debug path can verify timing and video content on-chip.
- Sits in the 25 MHz pixel domain, connected in parallel with the DAC outputs.

Parameters:
H_TOTAL, 800, expected clocks per line (hsync fall to hsync fall)
H_ACTIVE, 640, expected active pixels per line
V_TOTAL, 525, expected lines per frame (vsync fall to vsync fall)
V_ACTIVE, 480, expected active lines per frame
LOCK_FRAMES, 2, consecutive good frames required to assert locked (1..15)

Ports:
clk_25mhz  input  1  pixel clock; all logic on rising edge
rst  input  1  synchronous, active-low reset
blank  input  1  0 = blanking interval, 1 = active video
hsync  input  1  horizontal sync, active-low
vsync  input  1  vertical sync, active-low
pixel_r  input  8  red component
pixel_g  input  8  green component
pixel_b  input  8  blue component
pix_valid  output  1  registered pixel is active and the monitor is not in SEARCH
pix_x  output  10  active-pixel column of the registered pixel
pix_y  output  10  active-line row of the registered pixel
pix_rgb  output  24  registered {r,g,b}
frame_done  output  1  one-cycle pulse when frame results update
h_total_meas  output  11  last measured line length
h_active_meas  output  11  last measured active pixels per line
v_total_meas  output  11  lines in last frame
v_active_meas  output  11  active lines in last frame
frame_sum  output  24  sum of active {r,g,b} words in last frame, mod 2^24
err_h  output  1  any line in last frame mismatched H_TOTAL or H_ACTIVE
err_v  output  1  last frame mismatched V_TOTAL or V_ACTIVE
locked  output  1  LOCK_FRAMES consecutive error-free frames seen

Behaviour:
- Reset (rst=0 at a clock edge): all outputs 0, all counters 0, state SEARCH. Reset mid-frame aborts the frame; no frame_done is generated.
- Input stage:
  - blank, hsync, vsync and pixel inputs are registered once.
  - Edges are detected between the registered value and a second delayed copy.
  - pix_valid, pix_x, pix_y and pix_rgb align with the first register stage, giving 1-cycle latency from input.
- Horizontal:
  - hcnt counts clocks and saturates at 2047.
  - xcnt counts active clocks (registered blank=1) and saturates at 2047.
  - pix_x = xcnt value before increment; pix_x saturates at 1023.
  - On registered hsync falling edge: h_total_meas <= hcnt+1 (saturating), h_active_meas <= xcnt, hcnt <= 0, xcnt <= 0.
  - On the same edge, outside SEARCH, set the sticky line_err if the values differ from H_TOTAL or H_ACTIVE.
- Vertical:
  - On hsync fall, lcnt increments (saturating at 2047).
  - If the closed line had xcnt>0, acnt increments and ycnt increments (pix_y = ycnt, saturating at 1023).
- Frame close on registered vsync falling edge:
  - If hsync also falls in the same cycle, the line is closed first and the frame count includes that line.
  - Outside SEARCH:
    - v_total_meas <= lcnt, v_active_meas <= acnt, frame_sum <= sum.
    - err_h <= line_err.
    - err_v <= (lcnt != V_TOTAL) || (acnt != V_ACTIVE).
    - frame_done pulses for 1 cycle.
  - In all states: lcnt, acnt, ycnt, sum and line_err are cleared.
- Checksum: sum <= sum + {r,g,b} (24-bit wrap) on each active registered pixel, only outside SEARCH.
- State machine:
  - SEARCH: pix_valid=0, no results. On vsync fall -> TRACK (frame counters cleared, so the first reported frame is complete).
  - TRACK: at each frame close, good = !err_h_new && !err_v_new.
    - good: goodcnt++ (saturating at LOCK_FRAMES); locked <= 1 once goodcnt reaches LOCK_FRAMES.
    - bad: goodcnt <= 0, locked <= 0 in the same cycle as frame_done.
- Missing sync: counters saturate; no wrap; no spurious frame_done.

Test Plan:
- Nominal 640x480@800x525, three full frames after reset release mid-frame:
  - The first partial frame gives no frame_done.
  - Each frame_done reports h_total_meas=800, h_active_meas=640, v_total_meas=525, v_active_meas=480, err_h=0, err_v=0.
  - locked=1 coincident with the 2nd frame_done.
- Constant pixel 0x010203 on all active pixels -> frame_sum=0x6E1000. Ramp pix_x=0..639 and pix_y=0..479 checked against the inputs delayed 1 cycle.
- One line shortened to 799 clocks in frame 4 -> that frame_done gives err_h=1 and locked=0; locked returns to 1 at the 2nd subsequent good frame.
- Frame with 524 lines -> err_v=1, v_total_meas=524, locked drops. hsync and vsync falling in the same cycle -> v_total_meas counts that line (525).
- rst=0 for 1 cycle mid-frame -> all outputs 0 the next cycle, state SEARCH, no frame_done until one full frame after the next vsync fall.
- vsync held high for 3000 lines -> no frame_done, internal line count saturated at 2047. Next vsync fall gives v_total_meas=2047, err_v=1.

Source files
------------

// File: rtl/vga_rx_monitor_if.sv
// Video bus between the VGA pixel source and its receivers.
// The source owns every signal; monitors only observe.
interface vga_rx_monitor_if;
   logic       blank;
   logic       hsync;
   logic       vsync;
   logic [7:0] pixel_r;
   logic [7:0] pixel_g;
   logic [7:0] pixel_b;

   modport master (output blank, hsync, vsync, pixel_r, pixel_g, pixel_b);
   modport slave  (input  blank, hsync, vsync, pixel_r, pixel_g, pixel_b);
endinterface

// File: rtl/vga_rx_monitor.sv
// VGA receive-side monitor: recovers pixel coordinates from blank/hsync/vsync,
// measures line and frame geometry and accumulates a per-frame pixel checksum.
module vga_rx_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int H_ACTIVE    = 640,
   parameter int V_TOTAL     = 525,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                   clk_25mhz,
   input  logic                   rst,
   vga_rx_monitor_if.slave        vid,
   output logic                   pix_valid,
   output logic [9:0]             pix_x,
   output logic [9:0]             pix_y,
   output logic [23:0]            pix_rgb,
   output logic                   frame_done,
   output logic [10:0]            h_total_meas,
   output logic [10:0]            h_active_meas,
   output logic [10:0]            v_total_meas,
   output logic [10:0]            v_active_meas,
   output logic [23:0]            frame_sum,
   output logic                   err_h,
   output logic                   err_v,
   output logic                   locked
);
   localparam logic [10:0] CNT_MAX    = 11'h7FF;
   localparam logic [9:0]  POS_MAX    = 10'h3FF;
   localparam logic [10:0] H_TOTAL_C  = 11'(H_TOTAL);
   localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
   localparam logic [10:0] V_TOTAL_C  = 11'(V_TOTAL);
   localparam logic [10:0] V_ACTIVE_C = 11'(V_ACTIVE);
   localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

   typedef enum logic {SEARCH, TRACK} state_t;

   state_t      state;
   logic        blank_q, hsync_q, vsync_q, hsync_d, vsync_d;
   logic [23:0] rgb_q;
   logic [10:0] hcnt, xcnt, lcnt, acnt;
   logic [9:0]  ycnt;
   logic [23:0] sum;
   logic        line_err;
   logic [3:0]  goodcnt;

   logic        hs_fall, vs_fall, line_bad;
   logic [10:0] h_total_new, lcnt_new, acnt_new;
   logic [9:0]  ycnt_new;
   logic        line_err_new, err_v_new, frame_good;
   logic [23:0] sum_new;
   logic [3:0]  goodcnt_inc;

   function automatic logic [10:0] sat_inc11(input logic [10:0] v);
      return (v == CNT_MAX) ? v : v + 11'd1;
   endfunction

   function automatic logic [9:0] sat_inc10(input logic [9:0] v);
      return (v == POS_MAX) ? v : v + 10'd1;
   endfunction

   // Line close is resolved before frame close so a coincident hsync/vsync
   // fall counts the closing line in the frame being reported.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and no latch is inferred.
      hs_fall      = hsync_d & ~hsync_q;
      vs_fall      = vsync_d & ~vsync_q;
      h_total_new  = sat_inc11(hcnt);
      lcnt_new     = lcnt;
      acnt_new     = acnt;
      ycnt_new     = ycnt;
      line_err_new = line_err;
      // Vertical-blanking lines carry no active pixels and are exempt from the width check.
      line_bad     = (h_total_new != H_TOTAL_C) || ((xcnt != 11'd0) && (xcnt != H_ACTIVE_C));
      if (hs_fall) begin
         lcnt_new = sat_inc11(lcnt);
         if (xcnt != 11'd0) begin
            acnt_new = sat_inc11(acnt);
            ycnt_new = sat_inc10(ycnt);
         end
         if (state == TRACK && line_bad) line_err_new = 1'b1;
      end
      sum_new = sum;
      if (blank_q && state == TRACK) sum_new = sum + rgb_q;
      err_v_new   = (lcnt_new != V_TOTAL_C) || (acnt_new != V_ACTIVE_C);
      frame_good  = !line_err_new && !err_v_new;
      goodcnt_inc = (goodcnt >= LOCK_C) ? LOCK_C : goodcnt + 4'd1;
   end

   assign pix_valid = blank_q && (state == TRACK);
   assign pix_x     = xcnt[10] ? POS_MAX : xcnt[9:0];
   assign pix_y     = ycnt;
   assign pix_rgb   = rgb_q;

   always_ff @(posedge clk_25mhz) begin
      // NOTE: reset is synchronous and clears every register, including results, so an aborted frame leaves nothing behind.
      if (!rst) begin
         state         <= SEARCH;
         blank_q       <= 1'b0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
         hsync_d       <= 1'b0;
         vsync_d       <= 1'b0;
         rgb_q         <= '0;
         hcnt          <= '0;
         xcnt          <= '0;
         lcnt          <= '0;
         acnt          <= '0;
         ycnt          <= '0;
         sum           <= '0;
         line_err      <= 1'b0;
         goodcnt       <= '0;
         frame_done    <= 1'b0;
         h_total_meas  <= '0;
         h_active_meas <= '0;
         v_total_meas  <= '0;
         v_active_meas <= '0;
         frame_sum     <= '0;
         err_h         <= 1'b0;
         err_v         <= 1'b0;
         locked        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every read below sees the pre-edge value.
         blank_q    <= vid.blank;
         hsync_q    <= vid.hsync;
         vsync_q    <= vid.vsync;
         rgb_q      <= {vid.pixel_r, vid.pixel_g, vid.pixel_b};
         hsync_d    <= hsync_q;
         vsync_d    <= vsync_q;
         frame_done <= 1'b0;

         if (hs_fall) begin
            h_total_meas  <= h_total_new;
            h_active_meas <= xcnt;
            hcnt          <= '0;
            xcnt          <= '0;
         end else begin
            hcnt <= sat_inc11(hcnt);
            if (blank_q) xcnt <= sat_inc11(xcnt);
         end

         lcnt     <= lcnt_new;
         acnt     <= acnt_new;
         ycnt     <= ycnt_new;
         line_err <= line_err_new;
         sum      <= sum_new;

         if (vs_fall) begin
            lcnt     <= '0;
            acnt     <= '0;
            ycnt     <= '0;
            sum      <= '0;
            line_err <= 1'b0;
            if (state == SEARCH) begin
               state <= TRACK;
            end else begin
               v_total_meas  <= lcnt_new;
               v_active_meas <= acnt_new;
               frame_sum     <= sum_new;
               err_h         <= line_err_new;
               err_v         <= err_v_new;
               frame_done    <= 1'b1;
               if (frame_good) begin
                  goodcnt <= goodcnt_inc;
                  locked  <= (goodcnt_inc == LOCK_C);
               end else begin
                  goodcnt <= '0;
                  locked  <= 1'b0;
               end
            end
         end
      end
   end
endmodule
